otter_intr_ctrl: RTL
====================

Name: otter_intr_ctrl

Overview:
Interrupt controller that sequences the CSR file's interrupt entry for the OTTER core. It synchronizes and edge-detects N external interrupt sources, latches them as pending, and selects one by fixed priority. It then handshakes with the pipeline to reach an instruction boundary and pulses INT_TAKEN into the CSR file, which saves mepc and clears mie. After that it blocks further entry until the pipeline reports mret.

Parameters:
N_SRC, 4, number of external interrupt sources (1..16)
CNT_W, 16, width of the saturating taken-interrupt counter

Ports:
CLK  input  1  system clock, all state on rising edge
RST  input  1  asynchronous active-high reset
IRQ  input  N_SRC  raw asynchronous interrupt lines; a rising edge requests service
INT_EN  input  N_SRC  per-source enable mask; gates selection only, not pending capture
CSR_MIE  input  1  global enable from the CSR file (mie bit 0)
PIPE_READY  input  1  pipeline is at an instruction boundary and may be redirected this cycle
MRET  input  1  one-cycle pulse: mret retired
INT_REQ  output  1  request to the pipeline to drain or stall for interrupt entry
INT_TAKEN  output  1  one-cycle pulse to the CSR file and the PC mux (selects mtvec)
INT_CAUSE  output  max(1,$clog2(N_SRC))  index of the source being or last serviced
INT_PENDING  output  N_SRC  current pending bits
INT_ACTIVE  output  1  handler in progress (ISR state)
INT_COUNT  output  CNT_W  interrupts taken since reset, saturating

Behaviour:
- Reset (async, any state, mid-handshake included): state IDLE. All outputs 0. Pending, synchronizers and counter cleared.
- Synchronizer flops reset to 0, so a line held high through reset release counts as one rising edge.
- Per source: 2-flop synchronizer plus a history flop. edge = sync2 & ~hist.
  - IRQ first sampled high at edge k -> pending set after edge k+2.
- Pending set/clear:
  - Pending is set by edge and cleared only by INT_TAKEN for the selected index.
  - Set and clear in the same cycle: set wins and the bit stays 1.
  - Repeated edges while pending are not counted (one service).
- Selection: eligible = pending & INT_EN. The lowest index wins, computed combinationally.
- FSM states: IDLE, REQ, TAKEN, ISR.
  - IDLE: if CSR_MIE & |eligible -> REQ. Latch INT_CAUSE = winner.
  - REQ: INT_REQ=1. Cause is frozen in REQ; later higher-priority edges wait.
    - If CSR_MIE=0 or eligible[cause]=0 (mask dropped) -> IDLE. Deassert INT_REQ; pending is untouched.
    - Else if PIPE_READY -> TAKEN.
  - TAKEN: INT_REQ=1 and INT_TAKEN=1 for exactly one cycle. Clear pending[cause]. INT_COUNT+1, saturating at all-ones. Unconditionally -> ISR.
  - ISR: INT_ACTIVE=1, INT_REQ=0. On MRET -> IDLE. No nesting.
- Latency: minimum 2 cycles from entering REQ to INT_TAKEN (REQ with PIPE_READY=1, then TAKEN). Source edge to INT_TAKEN is at least 5 clocks.
- Ignored inputs:
  - MRET outside ISR.
  - PIPE_READY outside REQ.
- INT_CAUSE holds its value in ISR and IDLE until the next IDLE->REQ.
- N_SRC=1: INT_CAUSE is 1 bit, always 0.

Decomposition:
- Package otter_intr_pkg holds:
  - state enum intr_state_t {IDLE, REQ, TAKEN, ISR};
  - function cause_w(n) = max(1,$clog2(n));
  - CSR address constants MTVEC=12'h305, MEPC=12'h341, MIE=12'h304, for the core-level integration.
- Sub-module otter_intr_sync: one-bit 2-flop synchronizer with history flop and edge output. Asynchronous reset to 0. Instantiated N_SRC times in a generate loop.

Test Plan:
- Single source: reset, CSR_MIE=1, INT_EN=4'hF, PIPE_READY=1, IRQ[2] rises at edge 10.
  - Pending[2] set after edge 12; INT_REQ after edge 13; INT_TAKEN pulses one cycle after edge 14.
  - INT_CAUSE=2, INT_COUNT=1, pending=0, INT_ACTIVE=1.
  - MRET pulse -> IDLE.
- Priority: IRQ[3] and IRQ[1] rise in the same cycle.
  - Source 1 is taken first. After MRET, source 3 is taken. INT_COUNT=2.
- Handshake stall and abort, case 1: in REQ, hold PIPE_READY=0 for 7 cycles.
  - INT_REQ stays high and no INT_TAKEN until PIPE_READY=1.
- Handshake stall and abort, case 2: in REQ, drop CSR_MIE.
  - Return to IDLE, pending retained. Re-raise CSR_MIE -> REQ again.
- Masking: pending[0] set with INT_EN[0]=0.
  - No INT_REQ. Set INT_EN[0]=1 -> entry with cause 0.
- Race and reset:
  - New IRQ[0] edge lands on the same cycle as its TAKEN clear -> pending[0] remains 1 after TAKEN.
  - Assert RST asynchronously while in TAKEN or ISR -> all outputs 0 immediately, state IDLE.
  - Preload INT_COUNT near saturation via forced value 16'hFFFE; three takes -> INT_COUNT stays 16'hFFFF.

Source files
------------

// File: rtl/otter_intr_pkg.sv
// Shared types and constants for the OTTER interrupt controller.
`default_nettype none

package otter_intr_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        TAKEN = 2'd2,
        ISR   = 2'd3
    } intr_state_t;

    // CSR addresses used when wiring the controller into the core.
    localparam logic [11:0] MTVEC = 12'h305;
    localparam logic [11:0] MEPC  = 12'h341;
    localparam logic [11:0] MIE   = 12'h304;

    function automatic int cause_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

`default_nettype wire

// File: rtl/otter_intr_sync.sv
// Two-flop synchronizer with a history flop; flags a synchronized rising edge.
`default_nettype none

module otter_intr_sync (
    input  logic clk,
    input  logic rst,
    input  logic irq,
    output logic rise
);

    logic sync1;
    logic sync2;
    logic hist;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            hist  <= 1'b0;
        end else begin
            sync1 <= irq;
            sync2 <= sync1;
            hist  <= sync2;
        end
    end

    assign rise = sync2 & ~hist;

endmodule

`default_nettype wire

// File: rtl/otter_intr_ctrl.sv
// Interrupt entry sequencer: edge capture, fixed-priority select, pipeline handshake.
`default_nettype none

module otter_intr_ctrl
    import otter_intr_pkg::*;
#(
    parameter int N_SRC = 4,
    parameter int CNT_W = 16
) (
    input  logic                         CLK,
    input  logic                         RST,
    input  logic [N_SRC-1:0]             IRQ,
    input  logic [N_SRC-1:0]             INT_EN,
    input  logic                         CSR_MIE,
    input  logic                         PIPE_READY,
    input  logic                         MRET,
    output logic                         INT_REQ,
    output logic                         INT_TAKEN,
    output logic [cause_w(N_SRC)-1:0]    INT_CAUSE,
    output logic [N_SRC-1:0]             INT_PENDING,
    output logic                         INT_ACTIVE,
    output logic [CNT_W-1:0]             INT_COUNT
);

    localparam int CW = cause_w(N_SRC);

    intr_state_t      state;
    intr_state_t      state_nxt;
    logic [N_SRC-1:0] rise;
    logic [N_SRC-1:0] pending;
    logic [N_SRC-1:0] eligible;
    logic [N_SRC-1:0] clr_mask;
    logic [CW-1:0]    winner;
    logic [CW-1:0]    cause;
    logic             load_cause;
    logic             req;
    logic             taken;
    logic             active;
    logic [CNT_W-1:0] taken_count;

    for (genvar i = 0; i < N_SRC; i++) begin : g_src
        otter_intr_sync u_sync (
            .clk  (CLK),
            .rst  (RST),
            .irq  (IRQ[i]),
            .rise (rise[i])
        );
    end

    assign eligible = pending & INT_EN;

    // Scan from the top so the lowest eligible index is the last writer.
    always_comb begin
        winner = '0;
        for (int i = N_SRC - 1; i >= 0; i--) begin
            if (eligible[i]) begin
                winner = CW'(i);
            end
        end
    end

    always_comb begin
        clr_mask = '0;
        for (int i = 0; i < N_SRC; i++) begin
            clr_mask[i] = taken && (cause == CW'(i));
        end
    end

    always_comb begin
        state_nxt  = state;
        load_cause = 1'b0;
        req        = 1'b0;
        taken      = 1'b0;
        active     = 1'b0;
        case (state)
            IDLE: begin
                if (CSR_MIE && (|eligible)) begin
                    state_nxt  = REQ;
                    load_cause = 1'b1;
                end
            end
            REQ: begin
                req = 1'b1;
                if (!CSR_MIE || !eligible[cause]) begin
                    state_nxt = IDLE;
                end else if (PIPE_READY) begin
                    state_nxt = TAKEN;
                end
            end
            TAKEN: begin
                req       = 1'b1;
                taken     = 1'b1;
                state_nxt = ISR;
            end
            ISR: begin
                active = 1'b1;
                if (MRET) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state       <= IDLE;
            cause       <= '0;
            pending     <= '0;
            taken_count <= '0;
        end else begin
            state <= state_nxt;
            if (load_cause) begin
                cause <= winner;
            end
            // A fresh edge in the clearing cycle must survive, so set is applied last.
            pending <= (pending & ~clr_mask) | rise;
            if (taken && (taken_count != {CNT_W{1'b1}})) begin
                taken_count <= taken_count + CNT_W'(1);
            end
        end
    end

    assign INT_REQ     = req;
    assign INT_TAKEN   = taken;
    assign INT_CAUSE   = cause;
    assign INT_PENDING = pending;
    assign INT_ACTIVE  = active;
    assign INT_COUNT   = taken_count;

endmodule

`default_nettype wire
